mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Types shared between the CPU-side memory blocks: the RAM handshake
// encoding and the native word.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported RAM between the icache and dcache. Data is
// favoured, but bounded by a streak limit so a waiting fetch is not starved.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       iREN,
    input  word_t      iaddr,
    output word_t      iload,
    output logic       iwait,
    input  logic       dREN,
    input  logic       dWEN,
    input  word_t      daddr,
    input  word_t      dstore,
    output word_t      dload,
    output logic       dwait,
    output logic       ramREN,
    output logic       ramWEN,
    output word_t      ramaddr,
    output word_t      ramstore,
    input  word_t      ramload,
    input  logic [1:0] ramstate
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t    state;
    state_t    next_state;
    logic [2:0] streak;
    ramstate_t ram_st;
    logic      d_req;
    logic      d_allowed;
    logic      i_done;
    logic      d_done;

    assign ram_st    = ramstate_t'(ramstate);
    assign d_req     = dREN | dWEN;
    assign d_allowed = (32'(streak) < MAX_D_STREAK) || !iREN;

    // Completion requires the owner to still be requesting; a dropped
    // request that meets ACCESS is treated as abandoned.
    assign i_done = (state == IACC) && iREN  && (ram_st == ACCESS);
    assign d_done = (state == DACC) && d_req && (ram_st == ACCESS);

    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (d_req && d_allowed) begin
                    next_state = DACC;
                end else if (iREN) begin
                    next_state = IACC;
                end else begin
                    next_state = IDLE;
                end
            end
            IACC: begin
                if (!iREN || ram_st == ACCESS || ram_st == ERROR) begin
                    next_state = IDLE;
                end
            end
            DACC: begin
                if (!d_req || ram_st == ACCESS || ram_st == ERROR) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        unique case (state)
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = !i_done;
            end
            DACC: begin
                ramWEN   = dWEN;
                ramREN   = dREN & !dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !d_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak <= '0;
        end else if (!iREN || i_done) begin
            streak <= '0;
        end else if (d_done && streak != 3'b111) begin
            streak <= streak + 3'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed per-cycle vector table for mem_arbiter plus a hand-written
// reset-during-access sequence.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       iREN;
    word_t      iaddr;
    word_t      iload;
    logic       iwait;
    logic       dREN;
    logic       dWEN;
    word_t      daddr;
    word_t      dstore;
    word_t      dload;
    logic       dwait;
    logic       ramREN;
    logic       ramWEN;
    word_t      ramaddr;
    word_t      ramstore;
    word_t      ramload;
    logic [1:0] ramstate;

    int n_vec = 0;
    int n_bad = 0;

    mem_arbiter #(.MAX_D_STREAK(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       i_ren;
        word_t      i_addr;
        logic       d_ren;
        logic       d_wen;
        word_t      d_addr;
        word_t      d_store;
        word_t      r_load;
        logic [1:0] r_state;
        logic       e_ren;
        logic       e_wen;
        word_t      e_addr;
        word_t      e_store;
        logic       e_iw;
        logic       e_dw;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string nm, input logic ir, input word_t ia,
                                input logic dr, input logic dw, input word_t da,
                                input word_t ds, input word_t rl, input logic [1:0] rs,
                                input logic er, input logic ew, input word_t ea,
                                input word_t es, input logic eiw, input logic edw);
        vec_t v;
        v.name = nm; v.i_ren = ir; v.i_addr = ia; v.d_ren = dr; v.d_wen = dw;
        v.d_addr = da; v.d_store = ds; v.r_load = rl; v.r_state = rs;
        v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es;
        v.e_iw = eiw; v.e_dw = edw;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        iREN = v.i_ren; iaddr = v.i_addr; dREN = v.d_ren; dWEN = v.d_wen;
        daddr = v.d_addr; dstore = v.d_store; ramload = v.r_load; ramstate = v.r_state;
    endtask

    task automatic check_vec(input vec_t v);
        logic ok;
        ok = (ramREN === v.e_ren) && (ramWEN === v.e_wen) && (ramaddr === v.e_addr) &&
             (ramstore === v.e_store) && (iwait === v.e_iw) && (dwait === v.e_dw) &&
             (iload === v.r_load) && (dload === v.r_load);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got ren=%0b wen=%0b addr=%h store=%h iw=%0b dw=%0b iload=%h dload=%h; want ren=%0b wen=%0b addr=%h store=%h iw=%0b dw=%0b load=%h",
                     v.name, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload,
                     v.e_ren, v.e_wen, v.e_addr, v.e_store, v.e_iw, v.e_dw, v.r_load);
        end
    endtask

    task automatic check(input string nm, input word_t got, input word_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        // name            iREN iaddr  dREN dWEN daddr  dstore        ramload       ramst    REN WEN addr   store         iw dw
        vq.push_back(mk("s1_idle",     1, 32'h40, 0,0, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s1_iacc",     1, 32'h40, 0,0, 32'h0,   32'h0,        32'h1234,     ACCESS, 1,0, 32'h40,  32'h0,        0,1));
        vq.push_back(mk("s1_back",     0, 32'h0,  0,0, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s2_arb",      1, 32'h44, 0,1, 32'h80,  32'hDEADBEEF, 32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s2_dbusy",    1, 32'h44, 0,1, 32'h80,  32'hDEADBEEF, 32'h0,        BUSY,   0,1, 32'h80,  32'hDEADBEEF, 1,1));
        vq.push_back(mk("s2_dacc",     1, 32'h44, 0,1, 32'h80,  32'hDEADBEEF, 32'h0,        ACCESS, 0,1, 32'h80,  32'hDEADBEEF, 1,0));
        vq.push_back(mk("s2_arb2",     1, 32'h44, 0,0, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s2_iacc",     1, 32'h44, 0,0, 32'h0,   32'h0,        32'hCAFE,     ACCESS, 1,0, 32'h44,  32'h0,        0,1));
        vq.push_back(mk("s2_off",      0, 32'h0,  0,0, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s3_arb1",     1, 32'h200,1,0, 32'h100, 32'h55,       32'h0,        ACCESS, 0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s3_d1",       1, 32'h200,1,0, 32'h100, 32'h55,       32'hA1,       ACCESS, 1,0, 32'h100, 32'h55,       1,0));
        vq.push_back(mk("s3_arb2",     1, 32'h200,1,0, 32'h100, 32'h55,       32'h0,        ACCESS, 0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s3_d2",       1, 32'h200,1,0, 32'h100, 32'h55,       32'hA2,       ACCESS, 1,0, 32'h100, 32'h55,       1,0));
        vq.push_back(mk("s3_arb3",     1, 32'h200,1,0, 32'h100, 32'h55,       32'h0,        ACCESS, 0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s3_d3",       1, 32'h200,1,0, 32'h100, 32'h55,       32'hA3,       ACCESS, 1,0, 32'h100, 32'h55,       1,0));
        vq.push_back(mk("s3_arb4",     1, 32'h200,1,0, 32'h100, 32'h55,       32'h0,        ACCESS, 0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s3_d4_rw",    1, 32'h200,1,1, 32'h100, 32'h55,       32'hA4,       ACCESS, 0,1, 32'h100, 32'h55,       1,0));
        vq.push_back(mk("s3_arb5",     1, 32'h200,1,0, 32'h100, 32'h55,       32'h0,        ACCESS, 0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s3_ifair",    1, 32'h200,1,0, 32'h100, 32'h55,       32'hB0,       ACCESS, 1,0, 32'h200, 32'h0,        0,1));
        vq.push_back(mk("s3_arb6",     1, 32'h200,1,0, 32'h100, 32'h55,       32'h0,        ACCESS, 0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s3_d5",       1, 32'h200,1,0, 32'h100, 32'h55,       32'hA5,       ACCESS, 1,0, 32'h100, 32'h55,       1,0));
        vq.push_back(mk("s3_off",      0, 32'h0,  0,0, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s4_arb",      1, 32'h210,1,0, 32'h110, 32'h66,       32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s4_busy1",    1, 32'h210,1,0, 32'h110, 32'h66,       32'h0,        BUSY,   1,0, 32'h110, 32'h66,       1,1));
        vq.push_back(mk("s4_busy2",    1, 32'h210,1,0, 32'h110, 32'h66,       32'h0,        BUSY,   1,0, 32'h110, 32'h66,       1,1));
        vq.push_back(mk("s4_busy3",    1, 32'h210,1,0, 32'h110, 32'h66,       32'h0,        BUSY,   1,0, 32'h110, 32'h66,       1,1));
        vq.push_back(mk("s4_acc",      1, 32'h210,1,0, 32'h110, 32'h66,       32'hC4,       ACCESS, 1,0, 32'h110, 32'h66,       1,0));
        vq.push_back(mk("s4_off",      0, 32'h0,  0,0, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s5_arb",      1, 32'h300,0,0, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s5_err",      1, 32'h300,0,0, 32'h0,   32'h0,        32'hEE,       ERROR,  1,0, 32'h300, 32'h0,        1,1));
        vq.push_back(mk("s5_rearb",    1, 32'h300,0,0, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s5_acc",      1, 32'h300,0,0, 32'h0,   32'h0,        32'hD5,       ACCESS, 1,0, 32'h300, 32'h0,        0,1));
        vq.push_back(mk("s5_off",      0, 32'h0,  0,0, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s6_arb",      0, 32'h0,  1,0, 32'h400, 32'h77,       32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1));
        vq.push_back(mk("s6_drop",     0, 32'h0,  0,0, 32'h400, 32'h77,       32'h0,        BUSY,   0,0, 32'h400, 32'h77,       1,1));
        vq.push_back(mk("s6_idle",     0, 32'h0,  0,0, 32'h400, 32'h77,       32'hF6,       ACCESS, 0,0, 32'h0,   32'h0,        1,1));

        nRST = 1'b0;
        drive(mk("init", 0, 32'h0, 0,0, 32'h0, 32'h0, 32'h0, FREE, 0,0, 32'h0, 32'h0, 1,1));
        repeat (2) @(negedge CLK);
        drive(mk("rst_state", 1, 32'h40, 1,1, 32'h80, 32'h9, 32'h0, ACCESS, 0,0, 32'h0, 32'h0, 1,1));
        #1 check_vec(mk("rst_state", 1, 32'h40, 1,1, 32'h80, 32'h9, 32'h0, ACCESS, 0,0, 32'h0, 32'h0, 1,1));
        @(negedge CLK);
        nRST = 1'b1;

        foreach (vq[k]) begin
            drive(vq[k]);
            #1 check_vec(vq[k]);
            @(negedge CLK);
        end

        // Reset mid data access: build streak=1, start a second write, then reset.
        iREN = 1'b1; iaddr = 32'h600; dREN = 1'b0; dWEN = 1'b1;
        daddr = 32'h500; dstore = 32'h11; ramload = 32'h0; ramstate = FREE;
        #1 check("r_arb_ren", {31'd0, ramWEN}, 32'd0);
        @(negedge CLK);
        ramstate = ACCESS;
        #1 check("r_first_done", {31'd0, dwait}, 32'd0);
        @(negedge CLK);
        ramstate = FREE;
        @(negedge CLK);
        ramstate = BUSY;
        #1 check("r_wen_before", {31'd0, ramWEN}, 32'd1);
        check("r_streak_before", {29'd0, dut.streak}, 32'd1);
        #1 nRST = 1'b0;
        ramstate = ACCESS;
        #1 check("r_wen_drop", {31'd0, ramWEN}, 32'd0);
        check("r_no_dwait", {31'd0, dwait}, 32'd1);
        check("r_addr_zero", ramaddr, 32'h0);
        check("r_streak_zero", {29'd0, dut.streak}, 32'd0);
        @(negedge CLK);
        check("r_held_idle", {31'd0, ramWEN}, 32'd0);
        nRST = 1'b1;
        ramstate = FREE;
        #1 check("r_post_arb", {30'd0, ramWEN, dwait}, 32'd1);
        @(negedge CLK);
        ramstate = ACCESS;
        #1 check("r_regrant", {30'd0, ramWEN, dwait}, 32'd2);
        check("r_regrant_addr", ramaddr, 32'h500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
